// File: rtl/clmul_pkg.sv
// Shared widths and FSM state type for the Karatsuba carry-less multiplier.
package clmul_pkg;

  localparam int unsigned W    = 16;
  localparam int unsigned HALF = W / 2;
  localparam int unsigned PW   = 2 * W - 1;
  localparam int unsigned PHW  = 2 * HALF - 1;

  typedef enum logic [2:0] {
    IDLE,
    MUL_LO,
    MUL_HI,
    MUL_MID,
    DONE
  } clmul_state_t;

endpackage

// File: rtl/clmul8_core.sv
// Combinational HALFxHALF carry-less multiplier: AND array feeding XOR trees.
module clmul8_core
  import clmul_pkg::*;
(
  input  logic [HALF-1:0] x,
  input  logic [HALF-1:0] y,
  output logic [PHW-1:0]  z
);

  always_comb begin
    z = '0;
    for (int i = 0; i < int'(HALF); i++) begin
      z = z ^ (PHW'(x & {HALF{y[i]}}) << i);
    end
  end

endmodule

// File: rtl/clmul16_karatsuba_seq.sv
// Sequential 16x16 carry-less multiplier: three Karatsuba partial products on one shared core.
// Optional build macro CLMUL_MID_SKIP_EN skips the middle product when either half-sum is zero.
module clmul16_karatsuba_seq
  import clmul_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] p,
  output logic          busy
);

  clmul_state_t    state, state_n;
  logic [HALF-1:0] a_lo, a_hi, b_lo, b_hi;
  logic [HALF-1:0] core_x, core_y;
  logic [PHW-1:0]  core_p;
  logic [PW-1:0]   acc, acc_n;
  logic            in_ready_q;
  logic            mid_skip;

`ifdef CLMUL_MID_SKIP_EN
  // A zero half-sum forces P1 to zero, so the middle cycle can be dropped.
  assign mid_skip = ~|(a_lo ^ a_hi) | ~|(b_lo ^ b_hi);
`else
  assign mid_skip = 1'b0;
`endif

  // Operand mux in front of the shared core, steered by the schedule.
  always_comb begin
    core_x = a_lo ^ a_hi;
    core_y = b_lo ^ b_hi;
    case (state)
      MUL_LO: begin
        core_x = a_lo;
        core_y = b_lo;
      end
      MUL_HI: begin
        core_x = a_hi;
        core_y = b_hi;
      end
      default: ;
    endcase
  end

  clmul8_core u_core (
    .x (core_x),
    .y (core_y),
    .z (core_p)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next state and overlap-sum recombination into the accumulator.
  always_comb begin
    state_n = state;
    acc_n   = acc;
    case (state)
      IDLE: begin
        if (in_valid) state_n = MUL_LO;
      end
      MUL_LO: begin
        acc_n   = PW'(core_p) ^ (PW'(core_p) << HALF);
        state_n = MUL_HI;
      end
      MUL_HI: begin
        acc_n   = acc ^ (PW'(core_p) << HALF) ^ (PW'(core_p) << W);
        state_n = mid_skip ? DONE : MUL_MID;
      end
      MUL_MID: begin
        acc_n   = acc ^ (PW'(core_p) << HALF);
        state_n = DONE;
      end
      DONE: begin
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc        <= '0;
      a_lo       <= '0;
      a_hi       <= '0;
      b_lo       <= '0;
      b_hi       <= '0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      acc        <= acc_n;
      out_valid  <= (state_n == DONE);
      busy       <= (state_n != IDLE);
      in_ready_q <= (state_n == IDLE);
      if (state == IDLE && in_valid) begin
        a_lo <= a[HALF-1:0];
        a_hi <= a[W-1:HALF];
        b_lo <= b[HALF-1:0];
        b_hi <= b[W-1:HALF];
      end
    end
  end

  assign in_ready = in_ready_q & ~rst;
  assign p        = acc;

endmodule

// File: tb/tb_clmul16_karatsuba_seq.sv
// Self-checking bench for clmul16_karatsuba_seq: directed table, corner sequences, random vs reference.
module tb_clmul16_karatsuba_seq;

`ifdef CLMUL_MID_SKIP_EN
  localparam bit SKIP_EN = 1'b1;
`else
  localparam bit SKIP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [30:0] p;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [15:0] va;
    logic [15:0] vb;
    logic [30:0] vp;
  } vec_t;

  vec_t vecs[5];

  clmul16_karatsuba_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Bit-serial polynomial product over GF(2).
  function automatic logic [30:0] clmul_ref(input logic [15:0] x, input logic [15:0] y);
    logic [30:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      if (y[i]) r = r ^ (31'(x) << i);
    end
    return r;
  endfunction

  function automatic int exp_lat(input logic [15:0] x, input logic [15:0] y);
    bit skip;
    skip = ((x[7:0] ^ x[15:8]) == 8'h00) || ((y[7:0] ^ y[15:8]) == 8'h00);
    return (SKIP_EN && skip) ? 2 : 3;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic wait_idle();
    int cyc;
    cyc = 0;
    while (!in_ready && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("in_ready_idle", 64'(in_ready), 64'(1));
  endtask

  // One full transaction; bp enables random out_ready backpressure.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_, input bit bp);
    int          lat;
    int          cyc;
    bit          done;
    logic [30:0] exp_p;
    exp_p = clmul_ref(ta, tb_);
    wait_idle();
    a = ta; b = tb_; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom);
    lat = 0;
    while (!out_valid && lat < 20) begin
      chk("busy", 64'(busy), 64'(1));
      chk("in_ready_busy", 64'(in_ready), 64'(0));
      in_valid = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    chk("latency", 64'(lat), 64'(exp_lat(ta, tb_)));
    chk("product", 64'(p), 64'(exp_p));
    cyc = 0;
    done = 1'b0;
    while (!done) begin
      out_ready = (!bp || cyc >= 8) ? 1'b1 : 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      cyc++;
      if (out_ready) begin
        chk("ov_drop", 64'(out_valid), 64'(0));
        done = 1'b1;
      end else begin
        chk("ov_hold", 64'(out_valid), 64'(1));
        chk("p_hold", 64'(p), 64'(exp_p));
      end
    end
    out_ready = 1'b0;
  endtask

  initial begin
    vecs[0] = '{16'h0003, 16'h0003, 31'h0000_0005};
    vecs[1] = '{16'h0102, 16'h0102, 31'h0001_0004};
    vecs[2] = '{16'h8000, 16'h8000, 31'h4000_0000};
    vecs[3] = '{16'hFFFF, 16'h0001, 31'h0000_FFFF};
    vecs[4] = '{16'h0101, 16'h0101, 31'h0001_0001};

    // Reset values while rst is held.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_p", 64'(p), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'(1));

    // Directed vectors, back to back; also cross-check the table against the model.
    foreach (vecs[i]) begin
      chk("table_model", 64'(clmul_ref(vecs[i].va, vecs[i].vb)), 64'(vecs[i].vp));
      run_op(vecs[i].va, vecs[i].vb, 1'b0);
    end

    // Hold in DONE for 5 cycles with stray in_valid pulses.
    wait_idle();
    a = 16'h0102; b = 16'h0102; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    begin
      int cyc;
      cyc = 0;
      while (!out_valid && cyc < 20) begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    for (int k = 0; k < 5; k++) begin
      chk("hold_out_valid", 64'(out_valid), 64'(1));
      chk("hold_p", 64'(p), 64'(31'h0001_0004));
      chk("hold_in_ready", 64'(in_ready), 64'(0));
      in_valid = ~in_valid;
      a = 16'hFFFF; b = 16'hFFFF;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("hold_p_last", 64'(p), 64'(31'h0001_0004));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("release_out_valid", 64'(out_valid), 64'(0));
    chk("release_busy", 64'(busy), 64'(0));
    chk("release_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    chk("no_capture_busy", 64'(busy), 64'(0));

    // Abort in MUL_HI.
    a = 16'h1234; b = 16'h5678; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_out_valid", 64'(out_valid), 64'(0));
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_in_ready", 64'(in_ready), 64'(0));
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk("abort_no_pulse", 64'(out_valid), 64'(0));
    end
    run_op(16'h0003, 16'h0005, 1'b0);
    chk("ref_0003x0005", 64'(clmul_ref(16'h0003, 16'h0005)), 64'(31'h0000_000F));

    // Random operands with random backpressure.
    for (int n = 0; n < 3000; n++) begin
      run_op(16'($urandom), 16'($urandom), 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
